// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the out-of-order RV32I core.
// Entries are allocated at tail when issued and filled from the reservation
// station and load/store result buses. They retire from head one per cycle.
// A committed branch whose direction was mispredicted flushes every entry.
// Optional macro ROB_QUERY_FORWARD_EN: the operand query ports also forward
// this cycle's broadcast results. When the macro is undefined, queries see
// only the registered entry state.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 issueValid,
  input  logic [1:0]           issueType,
  input  logic [4:0]           issueDest,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueAltPc,
  output logic [ROB_WIDTH-1:0] issueRobIndex,
  output logic                 full,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsUpdateVal,
  input  logic                 lsbUpdate,
  input  logic [ROB_WIDTH-1:0] lsbRobIndex,
  input  logic [31:0]          lsbUpdateVal,
  input  logic [ROB_WIDTH-1:0] queryIndex1,
  input  logic [ROB_WIDTH-1:0] queryIndex2,
  output logic                 queryReady1,
  output logic                 queryReady2,
  output logic [31:0]          queryVal1,
  output logic [31:0]          queryVal2,
  output logic                 commitRegValid,
  output logic [4:0]           commitDest,
  output logic [31:0]          commitVal,
  output logic [ROB_WIDTH-1:0] commitRobIndex,
  output logic                 commitStore,
  output logic                 flush,
  output logic [31:0]          flushPc
);
  localparam int Depth = 1 << ROB_WIDTH;
  localparam logic [1:0] TypeReg    = 2'b00;
  localparam logic [1:0] TypeStore  = 2'b01;
  localparam logic [1:0] TypeBranch = 2'b10;

  logic [Depth-1:0] busy, ready;
  logic [1:0]       kindMem  [Depth];
  logic [4:0]       destMem  [Depth];
  logic             predMem  [Depth];
  logic [31:0]      altPcMem [Depth];
  logic [31:0]      valMem   [Depth];

  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;
  logic                 issueAccept, commitFire, mispredict;

  assign issueRobIndex = tail;
  assign full          = (count == (ROB_WIDTH+1)'(Depth));
  assign issueAccept   = issueValid && !full;
  assign commitFire    = busy[head] && ready[head];
  assign mispredict    = commitFire && (kindMem[head] == TypeBranch) &&
                         (valMem[head][0] != predMem[head]);

  // Operand lookup; a non-busy entry never reports ready.
  always_comb begin
    queryReady1 = busy[queryIndex1] && ready[queryIndex1];
    queryVal1   = valMem[queryIndex1];
    queryReady2 = busy[queryIndex2] && ready[queryIndex2];
    queryVal2   = valMem[queryIndex2];
`ifdef ROB_QUERY_FORWARD_EN
    // Bus forwarding; lsb is checked last so it wins on an index collision.
    if (rsUpdate && rsRobIndex == queryIndex1 && busy[queryIndex1]) begin
      queryReady1 = 1'b1;
      queryVal1   = rsUpdateVal;
    end
    if (lsbUpdate && lsbRobIndex == queryIndex1 && busy[queryIndex1]) begin
      queryReady1 = 1'b1;
      queryVal1   = lsbUpdateVal;
    end
    if (rsUpdate && rsRobIndex == queryIndex2 && busy[queryIndex2]) begin
      queryReady2 = 1'b1;
      queryVal2   = rsUpdateVal;
    end
    if (lsbUpdate && lsbRobIndex == queryIndex2 && busy[queryIndex2]) begin
      queryReady2 = 1'b1;
      queryVal2   = lsbUpdateVal;
    end
`endif
  end

  // Entry payload storage; no reset is needed because busy gates every use.
  always_ff @(posedge clockIn) begin
    if (issueAccept && !mispredict) begin
      kindMem[tail]  <= issueType;
      destMem[tail]  <= issueDest;
      predMem[tail]  <= issuePredTaken;
      altPcMem[tail] <= issueAltPc;
    end
    if (rsUpdate && busy[rsRobIndex] && !mispredict)
      valMem[rsRobIndex] <= rsUpdateVal;
    if (lsbUpdate && busy[lsbRobIndex] && !mispredict)
      valMem[lsbRobIndex] <= lsbUpdateVal;
  end

  // Control state: allocation, capture, in-order retirement and flush.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      busy           <= '0;
      ready          <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commitRegValid <= 1'b0;
      commitStore    <= 1'b0;
      flush          <= 1'b0;
      commitDest     <= '0;
      commitVal      <= '0;
      commitRobIndex <= '0;
      flushPc        <= '0;
    end else begin
      commitRegValid <= 1'b0;
      commitStore    <= 1'b0;
      flush          <= 1'b0;
      if (mispredict) begin
        // Wrong path: drop everything, including this edge's issue/updates.
        busy    <= '0;
        ready   <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        flush   <= 1'b1;
        flushPc <= altPcMem[head];
      end else begin
        if (commitFire) begin
          busy[head]     <= 1'b0;
          ready[head]    <= 1'b0;
          head           <= head + 1'b1;
          commitRegValid <= (kindMem[head] == TypeReg) && (destMem[head] != 5'd0);
          commitStore    <= (kindMem[head] == TypeStore);
          commitDest     <= destMem[head];
          commitVal      <= valMem[head];
          commitRobIndex <= head;
        end
        if (issueAccept) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        // lsb last so it wins when both buses hit the same entry.
        if (rsUpdate && busy[rsRobIndex])   ready[rsRobIndex]  <= 1'b1;
        if (lsbUpdate && busy[lsbRobIndex]) ready[lsbRobIndex] <= 1'b1;
        count <= count + (ROB_WIDTH+1)'(issueAccept) - (ROB_WIDTH+1)'(commitFire);
      end
    end
  end
endmodule
